// File: rtl/mux_pkg.sv
// Shared constants for the 16-to-1 registered mux and its 4-to-1 building block.
package mux_pkg;

  localparam int unsigned MUX_N      = 16;
  localparam int unsigned MUX_SEL_W  = 4;
  localparam int unsigned MUX_LEAF_N = 4;
  localparam int unsigned MUX_LEAF_W = 2;

  localparam logic F_RST = 1'b0;

endpackage

// File: rtl/mux_4to1.sv
// Combinational 4-to-1 bit selector: y = d[sel], d indexed ascending from 0.
module mux_4to1
  import mux_pkg::*;
(
  input  logic [0:MUX_LEAF_N-1] d,
  input  logic [MUX_LEAF_W-1:0] sel,
  output logic                  y
);

  // X/Z on sel propagates as normal simulation semantics
  assign y = d[sel];

endmodule

// File: rtl/mux_16to1.sv
// 16-to-1 single-bit mux built from a two-level tree of 4-to-1 stages, registered output.
// Optional MUX16_IN_REG_EN adds enable-gated input registers (2-cycle latency).
module mux_16to1
  import mux_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [0:MUX_N-1]     w,
  input  logic [MUX_SEL_W-1:0] s,
  output logic                 f
);

  logic [0:MUX_N-1]      w_data;
  logic [MUX_SEL_W-1:0]  w_sel;
  logic                  w_load;
  logic [0:MUX_LEAF_N-1] w_stage;
  logic                  w_sel_bit;
  logic                  r_f;

`ifdef MUX16_IN_REG_EN
  logic [0:MUX_N-1]      r_w;
  logic [MUX_SEL_W-1:0]  r_s;
  logic                  r_en_q;

  // Input capture; the mux sees the copies taken on the last enabled edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_w    <= '0;
      r_s    <= '0;
      r_en_q <= 1'b0;
    end else begin
      r_en_q <= en;
      if (en) begin
        r_w <= w;
        r_s <= s;
      end
    end
  end

  assign w_data = r_w;
  assign w_sel  = r_s;
  assign w_load = r_en_q;
`else
  assign w_data = w;
  assign w_sel  = s;
  assign w_load = en;
`endif

  // Leaf stage k covers w[4k..4k+3], selected by the low select bits
  for (genvar k = 0; k < int'(MUX_LEAF_N); k++) begin : g_leaf
    mux_4to1 u_leaf (
      .d   (w_data[k*MUX_LEAF_N +: MUX_LEAF_N]),
      .sel (w_sel[MUX_LEAF_W-1:0]),
      .y   (w_stage[k])
    );
  end

  mux_4to1 u_root (
    .d   (w_stage),
    .sel (w_sel[MUX_SEL_W-1:MUX_LEAF_W]),
    .y   (w_sel_bit)
  );

  // Output register: reset wins over load
  always_ff @(posedge clk) begin
    if (rst) begin
      r_f <= F_RST;
    end else if (w_load) begin
      r_f <= w_sel_bit;
    end
  end

  assign f = r_f;

endmodule

// File: tb/tb_mux_16to1.sv
// Self-checking bench for mux_16to1; expected f values queued at drive time, popped after each edge.
// Tracks the MUX16_IN_REG_EN build with a two-stage reference.
module tb_mux_16to1;

  logic        clk;
  logic        rst;
  logic        en;
  logic [0:15] w;
  logic [3:0]  s;
  logic        f;

  int n_total;
  int n_pass;

  logic sb_q[$];
  string tag_q[$];

  // reference state
  logic        m_f;
  logic [0:15] m_w;
  logic [3:0]  m_s;
  logic        m_en;

  mux_16to1 dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .w   (w),
    .s   (s),
    .f   (f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input logic got, input logic exp, input string tag);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: f=%b expected %b", tag, got, exp);
  endtask

  // One clock: apply inputs, queue the predicted f, then compare after the edge
  task automatic step(input logic r, input logic e, input logic [0:15] ww,
                      input logic [3:0] ss, input string tag);
    logic nf;
    rst = r; en = e; w = ww; s = ss;
`ifdef MUX16_IN_REG_EN
    nf = r ? 1'b0 : (m_en ? m_w[m_s] : m_f);
    if (r) begin
      m_w = '0; m_s = '0; m_en = 1'b0;
    end else begin
      m_en = e;
      if (e) begin
        m_w = ww; m_s = ss;
      end
    end
`else
    nf = r ? 1'b0 : (e ? ww[ss] : m_f);
`endif
    m_f = nf;
    sb_q.push_back(nf);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    check(f, sb_q.pop_front(), tag_q.pop_front());
  endtask

  initial begin
    logic [0:15] alt;
    logic [0:15] walk;
    n_total = 0; n_pass = 0;
    m_f = 1'b0; m_w = '0; m_s = '0; m_en = 1'b0;
    alt = 16'b0101010101010101;
    rst = 1'b1; en = 1'b1; w = 16'hFFFF; s = 4'd0;

    // reset with all ones on w, then release with s=0
    step(1'b1, 1'b1, 16'hFFFF, 4'd0, "reset0");
    step(1'b1, 1'b1, 16'hFFFF, 4'd0, "reset1");
    check(f, 1'b0, "reset_const");
    step(1'b0, 1'b1, 16'hFFFF, 4'd0, "release0");
    step(1'b0, 1'b1, 16'hFFFF, 4'd0, "release1");
    check(f, 1'b1, "release_const");

    // alternating sweep with a one-cycle reset pulse in the middle
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, alt, 4'(i), $sformatf("alt_s%0d", i));
      if (i == 7) begin
        step(1'b1, 1'b1, alt, 4'(i), "alt_midrst");
        check(f, 1'b0, "alt_midrst_const");
      end
    end
    step(1'b0, 1'b1, alt, 4'd15, "alt_flush");
    check(f, 1'b1, "alt_s15_const");

    // walking one checks ascending index order
    for (int k = 0; k < 16; k++) begin
      walk = '0;
      walk[k] = 1'b1;
      for (int j = 0; j < 16; j++)
        step(1'b0, 1'b1, walk, 4'(j), $sformatf("walk_k%0d_s%0d", k, j));
    end
    step(1'b0, 1'b1, 16'h8000, 4'd0, "msb_lit0");
    step(1'b0, 1'b1, 16'h8000, 4'd0, "msb_lit1");
    check(f, 1'b1, "msb_lit_const");

    // enable hold: load w[3]=1, then drop en and point at a zero bit
    step(1'b0, 1'b1, 16'h1000, 4'd3, "hold_load0");
    step(1'b0, 1'b1, 16'h1000, 4'd3, "hold_load1");
    check(f, 1'b1, "hold_load_const");
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b0, 16'h1000, 4'd0, $sformatf("hold_c%0d", i));
    check(f, 1'b1, "hold_const");
    step(1'b0, 1'b1, 16'h1000, 4'd0, "hold_rel0");
`ifdef MUX16_IN_REG_EN
    check(f, 1'b1, "hold_rel_lat2_const");
`else
    check(f, 1'b0, "hold_rel_const");
`endif
    step(1'b0, 1'b1, 16'h1000, 4'd0, "hold_rel1");
    check(f, 1'b0, "hold_rel1_const");

    // single select step 0 -> 1 on the alternating word
    step(1'b0, 1'b1, alt, 4'd0, "sstep_pre0");
    step(1'b0, 1'b1, alt, 4'd0, "sstep_pre1");
    step(1'b0, 1'b1, alt, 4'd1, "sstep_e1");
`ifdef MUX16_IN_REG_EN
    check(f, 1'b0, "sstep_e1_const");
`else
    check(f, 1'b1, "sstep_e1_const");
`endif
    step(1'b0, 1'b1, alt, 4'd1, "sstep_e2");
    check(f, 1'b1, "sstep_e2_const");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
